// File: rtl/spi_pkg.sv
// Shared definitions for the SPI manager engine: FSM state encoding,
// SPI mode constants and byte geometry.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam logic [2:0] SPI_LAST_BIT = 3'(SPI_BYTE_W - 1);

    // {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        TRAIL = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_clock_divider.sv
// Half-period timer for SCLK: pulses half_tick_o once every clock_div_i+1
// clocks while running; restart_i holds the count at zero.
module spi_clock_divider
    import spi_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 restart_i,
    input  logic [DIV_WIDTH-1:0] clock_div_i,
    output logic                 half_tick_o
);

    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic [DIV_WIDTH-1:0] div_cnt_d;

    // Equality compare means an all-ones divider never needs a wider counter.
    always_comb begin
        half_tick_o = !restart_i && (div_cnt_q == clock_div_i);
        if (restart_i || half_tick_o) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/spi_manager_engine.sv
// Byte-serial SPI manager: shifts a streamed byte out on MOSI (MSB first)
// in any CPOL/CPHA mode while capturing MISO into rx_data.
module spi_manager_engine
    import spi_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  clock_div,
    input  logic                  cs_select,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    output logic                  rx_valid,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs
);

    spi_state_e state_q, state_d;

    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [SPI_BYTE_W-1:0] tx_sh_q, tx_sh_d;
    logic [SPI_BYTE_W-1:0] rx_sh_q, rx_sh_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_q, cs_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic [SPI_BYTE_W-1:0] rx_shift_next;

    logic accept;
    logic half_tick;

    assign accept = tx_valid && (state_q == IDLE);

    spi_clock_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_div (
        .clock       (clock),
        .reset_n     (reset_n),
        .restart_i   (state_q == IDLE),
        .clock_div_i (div_q),
        .half_tick_o (half_tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LEAD;
            LEAD:    if (half_tick) state_d = TRAIL;
            TRAIL:   if (half_tick) state_d = (bit_cnt_q == SPI_LAST_BIT) ? IDLE : LEAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpol_d        = cpol_q;
        cpha_d        = cpha_q;
        div_d         = div_q;
        tx_sh_d       = tx_sh_q;
        rx_sh_d       = rx_sh_q;
        bit_cnt_d     = bit_cnt_q;
        sclk_d        = sclk_q;
        mosi_d        = mosi_q;
        cs_d          = cs_q;
        rx_valid_d    = 1'b0;
        rx_data_d     = rx_data_q;
        rx_shift_next = {rx_sh_q[SPI_BYTE_W-2:0], miso};

        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                cs_d   = !cs_select;
                if (accept) begin
                    cpol_d    = cpol;
                    cpha_d    = cpha;
                    div_d     = clock_div;
                    tx_sh_d   = tx_data;
                    rx_sh_d   = '0;
                    bit_cnt_d = '0;
                    if (!cpha) mosi_d = tx_data[SPI_BYTE_W-1];
                end
            end
            LEAD: begin
                if (half_tick) begin
                    sclk_d = !cpol_q;
                    if (!cpha_q) begin
                        rx_sh_d = rx_shift_next;
                    end else begin
                        mosi_d = tx_sh_q[SPI_BYTE_W-1];
                    end
                end
            end
            TRAIL: begin
                if (half_tick) begin
                    sclk_d    = cpol_q;
                    tx_sh_d   = {tx_sh_q[SPI_BYTE_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (cpha_q) rx_sh_d = rx_shift_next;
                    if (!cpha_q && (bit_cnt_q != SPI_LAST_BIT)) begin
                        mosi_d = tx_sh_q[SPI_BYTE_W-2];
                    end
                    // Last trailing edge: publish the byte as the FSM returns to IDLE.
                    if (bit_cnt_q == SPI_LAST_BIT) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = cpha_q ? rx_shift_next : rx_sh_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            div_q      <= div_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs       = cs_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule
